// File: rtl/array_42_ctrl.sv
// Initiator for the 4096x20 masked single-port SRAM macro: clears every entry after
// reset, then maps a valid/ready request stream onto RW0 and queues read data in order.
//
// state   | meaning
// ST_INIT | sweeping INIT_VALUE into every entry, one write per cycle
// ST_RUN  | serving client requests, init_done high
module array_42_ctrl #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 20,
    parameter int MASK_W     = 4,
    parameter int RESP_DEPTH = 2,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              RW0_clk,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam int OCC_W  = $clog2(RESP_DEPTH + 1);
    localparam int USED_W = OCC_W + 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              inflight;
    logic [DATA_W-1:0] q_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  q_head;
    logic [PTR_W-1:0]  q_tail;
    logic [OCC_W-1:0]  q_occ;

    logic              pop;
    logic              accept;
    logic              rd_accept;
    logic [USED_W-1:0] used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign RW0_clk    = clock;
    assign resp_valid = (q_occ != '0);
    assign resp_data  = q_mem[q_head];
    assign pop        = resp_valid && resp_ready;

    // A head popped this cycle frees its slot before the new read's data lands,
    // which is what lets back-to-back reads stream at full rate.
    assign used      = USED_W'(q_occ) + USED_W'(inflight) - USED_W'(pop);
    assign req_ready = !reset && (state == ST_RUN) && (used < USED_W'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_write;

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = req_addr;
        RW0_wmask = '0;
        RW0_wdata = req_wdata;
        if (!reset && state == ST_INIT) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt;
            RW0_wmask = '1;
            RW0_wdata = INIT_VALUE;
        end else if (accept) begin
            RW0_en    = 1'b1;
            RW0_wmode = req_write;
            RW0_wmask = req_write ? req_mask : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_W'(1);
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= 1'b0;
            q_head   <= '0;
            q_tail   <= '0;
            q_occ    <= '0;
        end else begin
            inflight <= rd_accept;
            if (inflight) begin
                q_tail <= ptr_inc(q_tail);
            end
            if (pop) begin
                q_head <= ptr_inc(q_head);
            end
            if (inflight && !pop) begin
                q_occ <= q_occ + OCC_W'(1);
            end else if (!inflight && pop) begin
                q_occ <= q_occ - OCC_W'(1);
            end
        end
    end

    // Macro data is valid the cycle after the read enable, i.e. while inflight is set.
    always_ff @(posedge clock) begin
        if (!reset && inflight) begin
            q_mem[q_tail] <= RW0_rdata;
        end
    end
endmodule
